// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared core-wide constants and the fetch packet type.
// Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Redirect, instruction-memory and decode-handshake bundle of the
//            fetch stage. master = fetch unit, slave = its environment.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            I_redirect;
  logic [XLEN-1:0] I_redirect_pc;
  logic [XLEN-1:0] O_imem_addr;
  logic [XLEN-1:0] I_imem_data;
  logic            O_valid;
  logic            I_ready;
  logic [XLEN-1:0] O_instr;
  logic [XLEN-1:0] O_pc;

  modport master (
    input  I_redirect, I_redirect_pc, I_imem_data, I_ready,
    output O_imem_addr, O_valid, O_instr, O_pc
  );

  modport slave (
    output I_redirect, I_redirect_pc, I_imem_data, I_ready,
    input  O_imem_addr, O_valid, O_instr, O_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Two-entry synchronous FIFO of fetch packets with flush.
//            Flush wins over push and pop in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
  import riscv_pkg::*;
(
  input  wire logic       I_clk,
  input  wire logic       I_rst_n,
  input  wire logic       I_push,
  input  wire fetch_pkt_t I_push_pkt,
  input  wire logic       I_pop,
  input  wire logic       I_flush,
  output logic [1:0]      O_count,
  output fetch_pkt_t      O_head
);

  fetch_pkt_t r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;

  logic       w_do_pop;
  logic       w_do_push;

  // Guard against popping an empty FIFO or pushing a full one without a pop
  assign w_do_pop  = I_pop && (r_count != 2'd0);
  assign w_do_push = I_push && ((r_count != 2'd2) || w_do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (I_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= I_push_pkt;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign O_count = r_count;
  assign O_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage. Owns the PC, issues one read per cycle
//            to a one-cycle-latency instruction memory while room remains in
//            the 2-entry output buffer, and flushes on redirect.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic     I_clk,
  input  wire logic     I_rst_n,
  fetch_unit_if.master  bus
);

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [1:0]      w_count;
  fetch_pkt_t      w_head;
  fetch_pkt_t      w_push_pkt;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [2:0]      w_occupancy;

  assign w_valid = (w_count != 2'd0);
  assign w_pop   = w_valid & bus.I_ready;

  // Slots committed after this edge: buffered minus leaving, plus the read
  // returning next cycle, plus the one we would issue now. Never exceed 2.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} + 3'd1 - {2'b00, w_pop};
  assign w_issue     = !bus.I_redirect && (w_occupancy <= 3'd2);

  // Data returning from last cycle's read is dropped if a redirect arrives now
  assign w_push        = r_inflight && !bus.I_redirect;
  assign w_push_pkt.pc    = r_inflight_pc;
  assign w_push_pkt.instr = bus.I_imem_data;

  // Program counter and outstanding-read tracking; redirect overrides issue
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.I_redirect) begin
      r_pc       <= bus.I_redirect_pc & ~XLEN'(3);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + XLEN'(4);
        r_inflight_pc <= r_pc;
      end
    end
  end

  fetch_fifo u_fifo (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_push     (w_push),
    .I_push_pkt (w_push_pkt),
    .I_pop      (w_pop),
    .I_flush    (bus.I_redirect),
    .O_count    (w_count),
    .O_head     (w_head)
  );

  assign bus.O_imem_addr = r_pc;
  assign bus.O_valid     = w_valid;
  assign bus.O_instr     = w_valid ? w_head.instr : INSTR_NOP;
  assign bus.O_pc        = w_valid ? w_head.pc : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: directed vector table,
//            hand-written reset sequences and randomized traffic against a
//            stream-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

  logic clk;
  logic rst_n;
  logic [31:0] mem_xor;

  int total;
  int bad;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ mem_xor;
  endfunction

  // Synchronous instruction memory, one-cycle latency
  always @(posedge clk) bus.I_imem_data <= mem_word(bus.O_imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic d, input logic [31:0] p,
                     input logic v, input logic [31:0] pc);
    vec_t e;
    e.ready = r; e.redir = d; e.rpc = p; e.exp_valid = v; e.exp_pc = pc;
    vecs.push_back(e);
  endtask

  // Stream-level model: after a stream start (reset or redirect) output is
  // valid from the second edge on, and PCs advance by 4 per accepted transfer.
  logic [31:0] m_pc;
  logic [31:0] m_start;
  int          m_age;

  task automatic model_reset();
    m_pc = TB_RESET_PC; m_start = TB_RESET_PC; m_age = 0;
  endtask

  task automatic overflow_chk();
    total++;
    if (dut.w_count > 2'd2 || (dut.w_push && dut.w_count == 2'd2 && !dut.w_pop)) begin
      bad++;
      $display("FAIL fifo_overflow: count=%0d push=%0b pop=%0b", dut.w_count, dut.w_push, dut.w_pop);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] rpc;
    logic r, d;
    total = 0; bad = 0;
    mem_xor = 32'h0;
    rst_n = 1'b0;
    bus.I_ready = 1'b0;
    bus.I_redirect = 1'b0;
    bus.I_redirect_pc = '0;
    bus.I_imem_data = '0;
    model_reset();

    #12;
    chk("reset_valid", {31'b0, bus.O_valid}, 32'd0);
    chk("reset_instr", bus.O_instr, 32'h0000_0013);
    chk("reset_pc", bus.O_pc, 32'd0);
    chk("reset_addr", bus.O_imem_addr, TB_RESET_PC);

    // ready, redirect, target, expected valid, expected pc
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h100);
    add(1, 0, 0, 1, 32'h104);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 32'h108);
    add(1, 0, 0, 1, 32'h108);
    add(1, 0, 0, 1, 32'h10c);
    add(1, 0, 0, 1, 32'h110);
    add(0, 0, 0, 1, 32'h114);
    add(0, 0, 0, 1, 32'h114);
    add(0, 1, 32'h2000, 1, 32'h114);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h2000);
    add(1, 1, 32'h3003, 1, 32'h2004);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h3000);
    add(1, 1, 32'hFFFF_FFF8, 1, 32'h3004);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32'hFFFF_FFF8);
    add(1, 0, 0, 1, 32'hFFFF_FFFC);
    add(1, 0, 0, 1, 32'h0000_0000);
    add(0, 0, 0, 1, 32'h0000_0004);
    add(0, 0, 0, 1, 32'h0000_0004);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      bus.I_ready       = vecs[i].ready;
      bus.I_redirect    = vecs[i].redir;
      bus.I_redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.O_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), bus.O_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), bus.O_instr, vecs[i].exp_pc);
      end else begin
        chk($sformatf("vec%0d_nop", i), bus.O_instr, 32'h0000_0013);
      end
      overflow_chk();
      @(negedge clk);
    end
    bus.I_redirect = 1'b0;

    // Buffer is full here; reset asynchronously between edges
    chk("pre_rst_valid", {31'b0, bus.O_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, bus.O_valid}, 32'd0);
    chk("async_rst_addr", bus.O_imem_addr, TB_RESET_PC);
    chk("async_rst_pc", bus.O_pc, 32'd0);
    chk("async_rst_instr", bus.O_instr, 32'h0000_0013);
    @(posedge clk);
    #1;
    chk("held_rst_valid", {31'b0, bus.O_valid}, 32'd0);

    // Randomized traffic against the stream model
    mem_xor = 32'hA5A5_0000;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 24) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      bus.I_ready = r;
      bus.I_redirect = d;
      bus.I_redirect_pc = rpc;
      #1;
      chk("rnd_valid", {31'b0, bus.O_valid}, {31'b0, (m_age >= 2)});
      if (m_age >= 2) begin
        chk("rnd_pc", bus.O_pc, m_pc);
        chk("rnd_instr", bus.O_instr, mem_word(m_pc));
      end
      if (m_age == 0) chk("rnd_start_addr", bus.O_imem_addr, m_start);
      overflow_chk();
      @(posedge clk);
      if (d) begin
        m_start = {rpc[31:2], 2'b00};
        m_pc = m_start;
        m_age = 0;
      end else begin
        if (m_age >= 2 && r) m_pc = m_pc + 32'd4;
        if (m_age < 2) m_age++;
      end
      @(negedge clk);
    end
    bus.I_redirect = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V core. Owns the program counter, drives the byte address of the synchronous instruction memory (one-cycle read latency, 32-bit word returned per address), and captures the returned words. It hands `{pc, instr}` pairs downstream to decode over a valid/ready handshake. A 2-entry buffer absorbs the memory's read latency so decode back-pressure never loses an instruction. A redirect from execute flushes everything in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `I_clk`  in  1  rising-edge clock.
- `I_rst_n`  in  1  asynchronous, active-low reset.
- `I_redirect`  in  1  one-cycle pulse from execute: taken branch, jump or trap.
- `I_redirect_pc`  in  32  target address, valid while `I_redirect`=1.
- `O_imem_addr`  out  32  byte address to instruction memory `I_address`.
- `I_imem_data`  in  32  instruction memory `O_data`; valid the cycle after the address is sampled.
- `O_valid`  out  1  `O_instr`/`O_pc` hold a fetched instruction.
- `I_ready`  in  1  decode accepts; transfer occurs when `O_valid & I_ready` at a rising edge.
- `O_instr`  out  32  instruction word at buffer head.
- `O_pc`  out  32  address of `O_instr`.

## Operation
- State:
  - `pc`: next address to issue.
  - `inflight`: 1 bit, a read was issued last cycle.
  - `inflight_pc`: address of that read.
  - 2-entry FIFO of {pc, instr} with `count` 0..2.
- `O_imem_addr` = `pc` at all times. Memory reads every cycle. A read counts as issued only when `issue`=1; otherwise its data is ignored.
- Each cycle:
  - `pop` = `O_valid & I_ready`.
  - `issue` = !`I_redirect` & (`count` - `pop` + `inflight` + 1 <= 2).
- Capture: if `inflight` and no redirect this cycle, push {`inflight_pc`, `I_imem_data`} into the FIFO.
- On `issue`: `pc` <= `pc`+4, mod 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); `inflight` <= 1; `inflight_pc` <= `pc`. Otherwise `inflight` <= 0 and `pc` holds.
- Redirect has priority over everything:
  - FIFO emptied (`count` <= 0), `inflight` <= 0.
  - `pc` <= {`I_redirect_pc`[31:2], 2'b00}; the low bits are silently cleared, no error is raised.
  - A `pop` in the same cycle is a completed transfer.
- `O_valid` = (`count` != 0). `O_instr`/`O_pc` come from the FIFO head. When empty, `O_instr`=32'h0000_0013 (NOP) and `O_pc`=0.
- Push and pop in the same cycle are both honoured. The issue rule guarantees no push ever finds the FIFO full; an overflow is a design bug that the bench asserts on.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `inflight`=0, `count`=0.
  - `O_valid`=0, `O_instr`=32'h0000_0013, `O_pc`=0, `O_imem_addr`=`RESET_PC`.
- Edges are numbered E1, E2, … starting from the first rising edge after `I_rst_n` deasserts.
  - E1: first issue.
  - E2: capture.
  - `O_valid`=1 from E2 on.
- Redirect sampled at edge Rk:
  - `O_valid`=0 after Rk.
  - Target is on `O_imem_addr` after Rk and issued at Rk+1.
  - Target instruction is valid after Rk+2; two-cycle bubble.
- Steady state with `I_ready`=1: one instruction per cycle, `count`=1, `O_pc` incrementing by 4.
- `I_ready`=0: after at most 2 edges the FIFO fills and issue stops with `count`=2, `inflight`=0. Releasing `I_ready` restores one instruction per cycle with no bubble.
- `I_rst_n` asserted mid-operation clears all state immediately (asynchronously). Memory data arriving afterwards is ignored.

## Structure
- Shared package `riscv_pkg`: `XLEN`=32, `INSTR_NOP`=32'h0000_0013, `RESET_PC_DEFAULT`, and a packed struct `fetch_pkt_t` {pc, instr}.
- One sub-module: `fetch_fifo`, a 2-entry synchronous FIFO of `fetch_pkt_t`.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - Asynchronous active-low reset.

## Test plan
- Reset release with `RESET_PC`=0x100, `I_ready`=1, memory returning word=address → `O_pc`/`O_instr` = 0x100, 0x104, 0x108 on consecutive cycles, first `O_valid` after E2.
- Hold `I_ready`=0 for 6 cycles, then release → no PC skipped or duplicated. Ordering is 0x100, 0x104, … and `count` never exceeds 2.
- Redirect to 0x2000 while `count`=2 and `I_ready`=0 → old entries dropped; next valid `O_pc`=0x2000 exactly 2 edges later, then 0x2004.
- Redirect to 0x3003 in the same cycle as a completed transfer → transfer counted once; next `O_pc`=0x3000.
- Fetch from 0xFFFF_FFF8 → `O_pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert `I_rst_n` mid-stream with `count`=2 → `O_valid`=0 and `O_imem_addr`=`RESET_PC` immediately, without waiting for a clock edge.
